// File: rtl/led_drv_pkg.sv
// Shared types and defaults for the serial LED chain driver.
//   led_drv_state_t : IDLE / SHIFT / LATCH frame sequencer states
//   LED_W           : default frame width (LED vector width)
//   LED_CLK_DIV     : default CLK cycles per SRCLK half-period / RCLK pulse
package led_drv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } led_drv_state_t;

  localparam int unsigned LED_W       = 16;
  localparam int unsigned LED_CLK_DIV = 2;

endpackage

// File: rtl/led_drv_timer.sv
// Half-period divider for the shift/latch clocks.
//   clk       : system clock
//   rst_n     : asynchronous active-low reset
//   clr       : hold the divider at zero (driver idle)
//   phase     : current SRCLK level
//   half_tick : last cycle of the current half-period / RCLK pulse
//   bit_done  : last cycle of a bit's SRCLK high phase
module led_drv_timer
  import led_drv_pkg::*;
#(
  parameter int unsigned CLK_DIV = LED_CLK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic phase,
  output logic half_tick,
  output logic bit_done
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt_q;
  logic [DIV_W-1:0] div_cnt_d;

  always_comb begin
    half_tick = (div_cnt_q == DIV_LAST);
    bit_done  = half_tick && phase;
    // Terminal count restarts at zero explicitly; the counter never wraps.
    if (clr || half_tick) begin
      div_cnt_d = '0;
    end else begin
      div_cnt_d = div_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

endmodule

// File: rtl/led_shift_driver.sv
// Drives a WIDTH-bit LED vector onto a chain of 595-style latching shift
// registers. A frame is sent whenever LED differs from the last frame sent,
// and once after every reset.
//   CLK   : system clock, rising edge
//   RST   : asynchronous active-low reset
//   LED   : LED vector, sampled only while idle
//   SER   : serial data, stable across each SRCLK high phase
//   SRCLK : shift clock (chain samples SER on its rising edge)
//   RCLK  : storage latch clock, one pulse per frame
//   BUSY  : high while a frame is in progress
module led_shift_driver
  import led_drv_pkg::*;
#(
  parameter int unsigned WIDTH     = LED_W,
  parameter int unsigned CLK_DIV   = LED_CLK_DIV,
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] LED,
  output logic             SER,
  output logic             SRCLK,
  output logic             RCLK,
  output logic             BUSY
);

  localparam int unsigned BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

  led_drv_state_t   state_q, state_d;
  logic [WIDTH-1:0] snap_q, snap_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic [WIDTH-1:0] snap_next;
  logic             pend_q, pend_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             ser_q, ser_d;
  logic             srclk_q, srclk_d;
  logic             rclk_q, rclk_d;
  logic             busy_q, busy_d;
  logic             half_tick;
  logic             bit_done;

  led_drv_timer #(
    .CLK_DIV (CLK_DIV)
  ) u_timer (
    .clk       (CLK),
    .rst_n     (RST),
    .clr       (state_q == IDLE),
    .phase     (srclk_q),
    .half_tick (half_tick),
    .bit_done  (bit_done)
  );

  always_comb begin
    state_d   = state_q;
    snap_d    = snap_q;
    last_d    = last_q;
    pend_d    = pend_q;
    bit_cnt_d = bit_cnt_q;
    ser_d     = ser_q;
    srclk_d   = srclk_q;
    rclk_d    = rclk_q;
    busy_d    = busy_q;
    snap_next = (MSB_FIRST != 0) ? (snap_q << 1) : (snap_q >> 1);

    unique case (state_q)
      IDLE: begin
        ser_d   = 1'b0;
        srclk_d = 1'b0;
        rclk_d  = 1'b0;
        busy_d  = 1'b0;
        if ((LED != last_q) || pend_q) begin
          snap_d    = LED;
          last_d    = LED;
          pend_d    = 1'b0;
          bit_cnt_d = '0;
          ser_d     = (MSB_FIRST != 0) ? LED[WIDTH-1] : LED[0];
          busy_d    = 1'b1;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_done) begin
          srclk_d = 1'b0;
          if (bit_cnt_q == BIT_LAST) begin
            ser_d   = 1'b0;
            rclk_d  = 1'b1;
            state_d = LATCH;
          end else begin
            // SER advances on the SRCLK falling edge so it is stable for the
            // whole following high phase.
            bit_cnt_d = bit_cnt_q + 1'b1;
            snap_d    = snap_next;
            ser_d     = (MSB_FIRST != 0) ? snap_next[WIDTH-1] : snap_next[0];
          end
        end else if (half_tick) begin
          srclk_d = 1'b1;
        end
      end
      LATCH: begin
        if (half_tick) begin
          rclk_d  = 1'b0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      snap_q    <= '0;
      last_q    <= '0;
      pend_q    <= 1'b1;
      bit_cnt_q <= '0;
      ser_q     <= 1'b0;
      srclk_q   <= 1'b0;
      rclk_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      snap_q    <= snap_d;
      last_q    <= last_d;
      pend_q    <= pend_d;
      bit_cnt_q <= bit_cnt_d;
      ser_q     <= ser_d;
      srclk_q   <= srclk_d;
      rclk_q    <= rclk_d;
      busy_q    <= busy_d;
    end
  end

  assign SER   = ser_q;
  assign SRCLK = srclk_q;
  assign RCLK  = rclk_q;
  assign BUSY  = busy_q;

endmodule

// File: tb/tb_led_shift_driver.sv
// Bench for led_shift_driver: default (MSB-first) instance plus an LSB-first
// instance, each feeding a 16-bit 595 model (shift on SRCLK rise, copy on
// RCLK rise).
module tb_led_shift_driver;

  logic        CLK = 1'b0;
  logic        RST;
  logic [15:0] LED;
  logic        SER, SRCLK, RCLK, BUSY;
  logic [15:0] led_lsb;
  logic        ser_lsb, srclk_lsb, rclk_lsb, busy_lsb;

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] sr = 16'hFFFF;
  logic [15:0] latch = 16'hDEAD;
  logic [15:0] sr_lsb = 16'hFFFF;
  logic [15:0] latch_lsb = 16'hDEAD;
  int          srclk_rises = 0;
  int          rclk_rises = 0;
  logic        seen_0003 = 1'b0;

  always #5 CLK = ~CLK;

  led_shift_driver u_dut (
    .CLK   (CLK),
    .RST   (RST),
    .LED   (LED),
    .SER   (SER),
    .SRCLK (SRCLK),
    .RCLK  (RCLK),
    .BUSY  (BUSY)
  );

  led_shift_driver #(
    .WIDTH     (16),
    .CLK_DIV   (2),
    .MSB_FIRST (0)
  ) u_dut_lsb (
    .CLK   (CLK),
    .RST   (RST),
    .LED   (led_lsb),
    .SER   (ser_lsb),
    .SRCLK (srclk_lsb),
    .RCLK  (rclk_lsb),
    .BUSY  (busy_lsb)
  );

  always @(posedge SRCLK) begin
    sr <= {sr[14:0], SER};
    srclk_rises <= srclk_rises + 1;
  end

  always @(posedge RCLK) begin
    latch <= sr;
    rclk_rises <= rclk_rises + 1;
    if (sr == 16'h0003) seen_0003 <= 1'b1;
  end

  always @(posedge srclk_lsb) sr_lsb <= {sr_lsb[14:0], ser_lsb};
  always @(posedge rclk_lsb) latch_lsb <= sr_lsb;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Called at a negedge. Waits for BUSY, then measures the frame in cycles,
  // optionally changing LED at given frame indices.
  task automatic measure(input string tag,
                         input logic [15:0] v1, input int at1,
                         input logic [15:0] v2, input int at2,
                         output int blen, output int rfirst,
                         output int rlen, output int rises);
    int w;
    int r0;
    w = 0;
    r0 = srclk_rises;
    blen = 0;
    rfirst = -1;
    rlen = 0;
    rises = 0;
    while (!BUSY && w < 200) begin
      @(negedge CLK);
      w++;
    end
    if (!BUSY) begin
      check({tag, " start timeout"}, 32'd0, 32'd1);
      return;
    end
    while (BUSY && blen < 500) begin
      if (blen == at1) LED = v1;
      if (blen == at2) LED = v2;
      if (RCLK) begin
        if (rfirst < 0) rfirst = blen;
        rlen++;
      end
      blen++;
      @(negedge CLK);
    end
    rises = srclk_rises - r0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int blen, rfirst, rlen, rises, r0;

    RST = 1'b0;
    LED = 16'h0000;
    led_lsb = 16'h0003;
    #12;
    check("reset outputs", {28'd0, SER, SRCLK, RCLK, BUSY}, 32'd0);
    check("reset outputs lsb", {28'd0, ser_lsb, srclk_lsb, rclk_lsb, busy_lsb}, 32'd0);
    @(negedge CLK);
    RST = 1'b1;

    // 1: refresh frame after reset with LED=0
    measure("t1", 16'h0, -1, 16'h0, -1, blen, rfirst, rlen, rises);
    check("t1 busy len", blen, 66);
    check("t1 rclk first", rfirst, 64);
    check("t1 rclk len", rlen, 2);
    check("t1 srclk rises", rises, 16);
    check("t1 latch", latch, 16'h0000);
    repeat (4) @(negedge CLK);
    check("t2 lsb latch", latch_lsb, 16'hC000);

    // 2: MSB-first pattern
    LED = 16'h8001;
    measure("t2", 16'h0, -1, 16'h0, -1, blen, rfirst, rlen, rises);
    check("t2 latch", latch, 16'h8001);
    check("t2 busy len", blen, 66);

    // 3: stable LED -> no activity
    r0 = srclk_rises;
    blen = 0;
    rlen = rclk_rises;
    for (int i = 0; i < 300; i++) begin
      @(negedge CLK);
      if (BUSY) blen++;
    end
    check("t3 srclk rises", srclk_rises - r0, 0);
    check("t3 rclk rises", rclk_rises - rlen, 0);
    check("t3 busy cycles", blen, 0);

    // 4: changes during a frame collapse to the latest value
    LED = 16'h0001;
    measure("t4a", 16'h0003, 10, 16'h0007, 30, blen, rfirst, rlen, rises);
    check("t4 first latch", latch, 16'h0001);
    measure("t4b", 16'h0, -1, 16'h0, -1, blen, rfirst, rlen, rises);
    check("t4 second latch", latch, 16'h0007);
    check("t4 second busy len", blen, 66);
    r0 = rclk_rises;
    repeat (200) @(negedge CLK);
    check("t4 no extra frame", rclk_rises - r0, 0);
    check("t4 0003 never latched", {31'd0, seen_0003}, 32'd0);

    // 5: reset mid-frame during bit 7
    LED = 16'h00FF;
    r0 = rclk_rises;
    begin
      int w;
      w = 0;
      while (!BUSY && w < 200) begin
        @(negedge CLK);
        w++;
      end
    end
    check("t5 frame started", {31'd0, BUSY}, 32'd1);
    repeat (30) @(negedge CLK);
    #1 RST = 1'b0;
    #1 check("t5 async outputs", {28'd0, SER, SRCLK, RCLK, BUSY}, 32'd0);
    #4 RST = 1'b1;
    @(negedge CLK);
    check("t5 no rclk", rclk_rises - r0, 0);
    check("t5 latch kept", latch, 16'h0007);
    measure("t5", 16'h0, -1, 16'h0, -1, blen, rfirst, rlen, rises);
    check("t5 refresh latch", latch, 16'h00FF);
    check("t5 refresh busy len", blen, 66);
    check("t5 refresh srclk rises", rises, 16);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
